readout_sequencer: RTL and testbench

//  Sequences readout of NCH ring-buffer channels after a trigger: walks the enabled channels

---
 rtl/readout_sequencer_if.sv | 38 +++
 rtl/readout_sequencer.sv | 177 +++++++++++++++++
 tb/tb_readout_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/readout_sequencer_if.sv
// Channel-side and stream-side signals of the readout sequencer.
// master: the sequencer. slave: the channels and the stream consumer.
// With HEADER_EN defined the bundle also carries out_header.
interface readout_sequencer_if #(
   parameter int NCH   = 4,
   parameter int SIZE  = 8,
   parameter int WIDTH = 12
);
   localparam int CHW = $clog2(NCH);

   logic [NCH-1:0]       rd_request;
   logic [SIZE-1:0]      howmany;
   logic [SIZE-1:0]      offset;
   logic [NCH*WIDTH-1:0] ch_dout;
   logic [CHW+WIDTH-1:0] out_data;
   logic                 out_valid;
   logic                 out_last;
   logic                 out_ready;
`ifdef HEADER_EN
   logic                 out_header;
`endif

   modport master (
`ifdef HEADER_EN
      output out_header,
`endif
      output rd_request, howmany, offset, out_data, out_valid, out_last,
      input  ch_dout, out_ready
   );

   modport slave (
`ifdef HEADER_EN
      input  out_header,
`endif
      input  rd_request, howmany, offset, out_data, out_valid, out_last,
      output ch_dout, out_ready
   );
endinterface

// File: rtl/readout_sequencer.sv
// Readout sequencer: walks the enabled ring-buffer channels lowest index
// first, strobes each channel's rd_request and forwards howmany words from
// its DOUT as a {channel, sample} tagged stream.
// Optional feature macro HEADER_EN: one header word {channel, howmany} with
// out_header=1 precedes each channel block, placed in the first latency
// cycle (needs RD_LAT>=2 and WIDTH>=SIZE).
//
// state  | meaning
// -------+--------------------------------------------------------
// IDLE   | waiting for a start rising cycle
// SEL    | pick lowest remaining channel, or finish when none left
// WAIT   | hold until the consumer can take a whole block
// REQ    | one-cycle rd_request strobe to the selected channel
// LAT    | channel read latency (header word on its first cycle)
// STREAM | forward howmany words, last one flagged
// DONE   | one-cycle done pulse
module readout_sequencer #(
   parameter int NCH    = 4,
   parameter int SIZE   = 8,
   parameter int WIDTH  = 12,
   parameter int RD_LAT = 2
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 start,
   input  logic                 abort,
   input  logic [NCH-1:0]       ch_mask,
   input  logic [SIZE-1:0]      howmany_i,
   input  logic [SIZE-1:0]      offset_i,
   output logic                 busy,
   output logic                 done,
   readout_sequencer_if.master  bus
);
   localparam int CHW = $clog2(NCH);

   typedef enum logic [2:0] {
      S_IDLE, S_SEL, S_WAIT, S_REQ, S_LAT, S_STREAM, S_DONE
   } state_t;

   state_t          state, state_n;
   logic [NCH-1:0]  mask_q, mask_n;
   logic [CHW-1:0]  ch_q, ch_n;
   logic [SIZE-1:0] word_q, word_n;
   logic [SIZE-1:0] howmany_q, howmany_n;
   logic [SIZE-1:0] offset_q, offset_n;
   logic [2:0]      lat_q, lat_n;
   logic            start_q;
   logic            hdr_q, hdr_n;
   logic [NCH-1:0]  rd_request_q;
   logic            out_valid_q, out_last_q, busy_q, done_q;
   logic [WIDTH-1:0] ch_word;

   // Next-state, counter and latch updates; abort overrides everything.
   always_comb begin
      state_n   = state;
      mask_n    = mask_q;
      ch_n      = ch_q;
      word_n    = word_q;
      howmany_n = howmany_q;
      offset_n  = offset_q;
      lat_n     = lat_q;
      hdr_n     = 1'b0;
      if (abort) begin
         state_n = S_IDLE;
         mask_n  = '0;
      end else begin
         case (state)
            S_IDLE: begin
               // start is edge-qualified so a held start never re-triggers
               if (start && !start_q) begin
                  mask_n    = ch_mask;
                  howmany_n = howmany_i;
                  offset_n  = offset_i;
                  state_n   = ((ch_mask == '0) || (howmany_i == '0)) ? S_DONE : S_SEL;
               end
            end
            S_SEL: begin
               if (mask_q == '0) begin
                  state_n = S_DONE;
               end else begin
                  for (int i = NCH - 1; i >= 0; i--) begin
                     if (mask_q[i]) ch_n = CHW'(i);
                  end
                  state_n = S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus.out_ready) state_n = S_REQ;
            end
            S_REQ: begin
               word_n = howmany_q;
               lat_n  = 3'(RD_LAT - 1);
               if (RD_LAT == 1) begin
                  state_n = S_STREAM;
               end else begin
                  state_n = S_LAT;
`ifdef HEADER_EN
                  hdr_n   = 1'b1;
`endif
               end
            end
            S_LAT: begin
               lat_n = lat_q - 3'd1;
               if (lat_q == 3'd1) state_n = S_STREAM;
            end
            S_STREAM: begin
               word_n = word_q - SIZE'(1);
               if (word_q == SIZE'(1)) begin
                  mask_n[ch_q] = 1'b0;
                  state_n      = S_SEL;
               end
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
         endcase
      end
   end

   // State, datapath registers and registered outputs decoded from the next state.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= S_IDLE;
         mask_q       <= '0;
         ch_q         <= '0;
         word_q       <= '0;
         howmany_q    <= '0;
         offset_q     <= '0;
         lat_q        <= '0;
         start_q      <= 1'b0;
         hdr_q        <= 1'b0;
         rd_request_q <= '0;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state        <= state_n;
         mask_q       <= mask_n;
         ch_q         <= ch_n;
         word_q       <= word_n;
         howmany_q    <= howmany_n;
         offset_q     <= offset_n;
         lat_q        <= lat_n;
         start_q      <= start;
         hdr_q        <= hdr_n;
         rd_request_q <= (state_n == S_REQ) ? (NCH'(1) << ch_n) : '0;
         out_valid_q  <= (state_n == S_STREAM) || hdr_n;
         out_last_q   <= (state_n == S_STREAM) && (word_n == SIZE'(1));
         busy_q       <= (state_n != S_IDLE);
         done_q       <= (state_n == S_DONE);
      end
   end

   // The channel word is passed straight through so it lines up with out_valid.
   assign ch_word = bus.ch_dout[int'(ch_q) * WIDTH +: WIDTH];

   // Tagged stream word: header carries howmany, data carries the channel sample.
   always_comb begin
      bus.out_data = '0;
      if (hdr_q) begin
         bus.out_data = {ch_q, WIDTH'(howmany_q)};
      end else if (out_valid_q) begin
         bus.out_data = {ch_q, ch_word};
      end
   end

   assign bus.rd_request = rd_request_q;
   assign bus.howmany    = howmany_q;
   assign bus.offset     = offset_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_last   = out_last_q;
`ifdef HEADER_EN
   assign bus.out_header = hdr_q;
`endif
   assign busy = busy_q;
   assign done = done_q;
endmodule

// File: tb/tb_readout_sequencer.sv
// Directed bench for readout_sequencer with a channel read-latency model
// and a queue of expected stream words. Build with HEADER_EN to cover the
// header variant.
module tb_readout_sequencer;
   localparam int NCH    = 4;
   localparam int SIZE   = 8;
   localparam int WIDTH  = 12;
   localparam int RD_LAT = 2;
   localparam int CHW    = $clog2(NCH);
`ifdef HEADER_EN
   localparam int FIRST_LAT = 1;
   localparam bit HDR_ON    = 1'b1;
`else
   localparam int FIRST_LAT = RD_LAT;
   localparam bit HDR_ON    = 1'b0;
`endif

   typedef struct packed {
      logic                 hdr;
      logic                 last;
      logic [CHW+WIDTH-1:0] data;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            start;
   logic            abort;
   logic [NCH-1:0]  ch_mask;
   logic [SIZE-1:0] howmany_i;
   logic [SIZE-1:0] offset_i;
   logic            busy;
   logic            done;

   readout_sequencer_if #(.NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH)) bus ();

   readout_sequencer #(.NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH), .RD_LAT(RD_LAT)) dut (
      .CLK       (clk),
      .RESET_N   (rst_n),
      .start     (start),
      .abort     (abort),
      .ch_mask   (ch_mask),
      .howmany_i (howmany_i),
      .offset_i  (offset_i),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   int             n_cmp = 0;
   int             n_mis = 0;
   int             cyc = 0;
   int             req_cyc = 0;
   bit             first_pend = 0;
   int             done_cnt = 0;
   bit             valid_seen = 0;
   logic [NCH-1:0] req_seen = '0;
   exp_t           exp_q[$];
   exp_t           e;
   int             age [NCH];
   logic [NCH-1:0] active;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] word_of(input int c, input int off, input int j);
      return WIDTH'(c * 300 + off * 7 + j + 1);
   endfunction

   // Channel model: DOUT word j is valid RD_LAT+j cycles after the rd_request cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active <= '0;
         for (int c = 0; c < NCH; c++) age[c] <= 0;
      end else begin
         for (int c = 0; c < NCH; c++) begin
            if (bus.rd_request[c]) begin
               active[c] <= 1'b1;
               age[c]    <= 1;
            end else if (active[c]) begin
               age[c] <= age[c] + 1;
            end
         end
      end
   end

   always_comb begin
      bus.ch_dout = '0;
      for (int c = 0; c < NCH; c++) begin
         if (active[c] && age[c] >= RD_LAT)
            bus.ch_dout[c*WIDTH +: WIDTH] = word_of(c, int'(bus.offset), age[c] - RD_LAT);
         else
            bus.ch_dout[c*WIDTH +: WIDTH] = 12'hBAD;
      end
   end

   // Stream monitor: pops the expected queue on every valid word.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.rd_request != '0) begin
            chk("rd_request_onehot", 32'($onehot(bus.rd_request)), 32'd1);
            req_seen   = req_seen | bus.rd_request;
            req_cyc    = cyc;
            first_pend = 1'b1;
         end
         if (bus.out_valid) begin
            valid_seen = 1'b1;
            if (first_pend) begin
               chk("first_word_latency", 32'(cyc - req_cyc), 32'(FIRST_LAT));
               first_pend = 1'b0;
            end
            if (exp_q.size() == 0) begin
               chk("unexpected_word", 32'(bus.out_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(bus.out_data), 32'(e.data));
               chk("out_last", 32'(bus.out_last), 32'(e.last));
`ifdef HEADER_EN
               chk("out_header", 32'(bus.out_header), 32'(e.hdr));
`endif
            end
         end else begin
            chk("out_last_without_valid", 32'(bus.out_last), 32'd0);
         end
         if (done) done_cnt++;
      end
   end

   task automatic push_block(input logic [NCH-1:0] m, input int hm, input int off);
      exp_t x;
      if (hm == 0) return;
      for (int c = 0; c < NCH; c++) begin
         if (m[c]) begin
            if (HDR_ON) begin
               x.hdr = 1'b1; x.last = 1'b0; x.data = {CHW'(c), WIDTH'(hm)};
               exp_q.push_back(x);
            end
            for (int j = 0; j < hm; j++) begin
               x.hdr = 1'b0; x.last = (j == hm - 1); x.data = {CHW'(c), word_of(c, off, j)};
               exp_q.push_back(x);
            end
         end
      end
   endtask

   task automatic do_start(input logic [NCH-1:0] m, input int hm, input int off);
      @(posedge clk); #1;
      ch_mask   = m;
      howmany_i = SIZE'(hm);
      offset_i  = SIZE'(off);
      start     = 1'b1;
      push_block(m, hm, off);
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   task automatic wait_word(input string tag, input int ch, input int budget);
      int n = 0;
      @(negedge clk);
      while (!(bus.out_valid === 1'b1 && int'(bus.out_data[CHW+WIDTH-1 -: CHW]) == ch) && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(tag, 32'(bus.out_valid), 32'd1);
   endtask

   initial begin
      int dc;
      rst_n = 1'b0; start = 1'b0; abort = 1'b0;
      ch_mask = '0; howmany_i = '0; offset_i = '0;
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_rd_request", 32'(bus.rd_request), 32'd0);
      chk("reset_howmany", 32'(bus.howmany), 32'd0);
      chk("reset_offset", 32'(bus.offset), 32'd0);
      rst_n = 1'b1;

      // two channels, three words each
      req_seen = '0;
      do_start(4'b0101, 3, 5);
      wait_done("t1_done", 100);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done), 32'd0);
      chk("t1_busy_after", 32'(busy), 32'd0);
      chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      chk("t1_requests", 32'(req_seen), 32'b0101);
      chk("t1_done_count", 32'(done_cnt), 32'd1);
      chk("t1_howmany_held", 32'(bus.howmany), 32'd3);

      // consumer not ready: no request until out_ready
      req_seen = '0;
      bus.out_ready = 1'b0;
      do_start(4'b1000, 3, 1);
      repeat (10) @(negedge clk);
      chk("t2_no_request", 32'(req_seen), 32'd0);
      chk("t2_busy_waiting", 32'(busy), 32'd1);
      bus.out_ready = 1'b1;
      wait_done("t2_done", 100);
      chk("t2_requests", 32'(req_seen), 32'b1000);
      chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

      // empty mask, then zero howmany
      req_seen = '0; valid_seen = 1'b0;
      do_start(4'b0000, 4, 0);
      chk("t3a_busy", 32'(busy), 32'd1);
      chk("t3a_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("t3a_busy_drop", 32'(busy), 32'd0);
      chk("t3a_done_drop", 32'(done), 32'd0);
      do_start(4'b1111, 0, 0);
      chk("t3b_busy", 32'(busy), 32'd1);
      chk("t3b_done", 32'(done), 32'd1);
      @(posedge clk); #1;
      chk("t3b_busy_drop", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t3_no_request", 32'(req_seen), 32'd0);
      chk("t3_no_valid", 32'(valid_seen), 32'd0);

      // abort on the second data word of channel 1
      req_seen = '0;
      dc = done_cnt;
      do_start(4'b0011, 5, 2);
      wait_word("t4_ch1_first", 1, 100);
      if (HDR_ON) @(negedge clk);
      @(negedge clk);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("t4_valid_dropped", 32'(bus.out_valid), 32'd0);
      chk("t4_last_absent", 32'(bus.out_last), 32'd0);
      chk("t4_busy_dropped", 32'(busy), 32'd0);
      chk("t4_words_left", 32'(exp_q.size()), 32'd3);
      exp_q.delete();
      repeat (5) @(negedge clk);
      chk("t4_no_done", 32'(done_cnt), 32'(dc));
      chk("t4_requests", 32'(req_seen), 32'b0011);
      do_start(4'b0001, 2, 3);
      wait_done("t4_restart_done", 100);
      chk("t4_restart_queue", 32'(exp_q.size()), 32'd0);

      // start while busy is ignored; held start does not re-trigger
      @(negedge clk);
      dc = done_cnt;
      do_start(4'b0110, 4, 9);
      wait_word("t5_first_word", 1, 100);
      start = 1'b1; ch_mask = 4'b1111; howmany_i = 8'd77; offset_i = 8'd33;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("t5_howmany_kept", 32'(bus.howmany), 32'd4);
      chk("t5_offset_kept", 32'(bus.offset), 32'd9);
      start = 1'b1;
      wait_done("t5_done", 200);
      repeat (3) @(negedge clk);
      chk("t5_held_start_ignored", 32'(busy), 32'd0);
      chk("t5_single_done", 32'(done_cnt - dc), 32'd1);
      chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
      start = 1'b0;

      // abort and start together in IDLE
      @(negedge clk);
      start = 1'b1; abort = 1'b1; ch_mask = 4'b0001; howmany_i = 8'd2;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      chk("t6_abort_wins", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t6_still_idle", 32'(busy), 32'd0);

      // maximum howmany
      do_start(4'b0001, 255, 0);
      wait_done("t7_max_done", 400);
      chk("t7_queue_empty", 32'(exp_q.size()), 32'd0);

      // reset in the middle of a block
      do_start(4'b0100, 10, 4);
      wait_word("t8_first_word", 2, 100);
      rst_n = 1'b0;
      #1;
      chk("t8_valid_reset", 32'(bus.out_valid), 32'd0);
      chk("t8_busy_reset", 32'(busy), 32'd0);
      chk("t8_howmany_reset", 32'(bus.howmany), 32'd0);
      chk("t8_offset_reset", 32'(bus.offset), 32'd0);
      exp_q.delete();
      first_pend = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

`ifdef HEADER_EN
      // header word ahead of a four-word block
      do_start(4'b0010, 4, 0);
      wait_done("t9_header_done", 100);
      chk("t9_queue_empty", 32'(exp_q.size()), 32'd0);
`endif

      repeat (3) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule
